// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the TX and RX paths.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

   localparam int DATA_BITS = 8;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick on the last count.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clock,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count_reg;

   assign tick = enable && (count_reg == LAST);

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= tick ? '0 : count_reg + CW'(1);
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, registered tx/tx_busy outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
import uart_pkg::*;

module uart_tx #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       clock,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_send,
   output logic       tx_busy,
   output logic       tx
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
   end

   tx_state_t            state_reg, state_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
   logic                 tx_reg, tx_next;
   logic                 busy_reg, busy_next;
   logic                 accept;
   logic                 tick;
`ifdef UART_TX_PARITY_EN
   logic                 parity_reg, parity_next;
`endif

   assign accept  = (state_reg == IDLE) && tx_send && !busy_reg;
   assign tx      = tx_reg;
   assign tx_busy = busy_reg;

   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clock  (clock),
      .rst    (rst),
      .clear  (accept),
      .enable (state_reg != IDLE),
      .tick   (tick)
   );

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         tx_reg      <= 1'b1;
         busy_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_reg  <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         shift_reg   <= shift_next;
         bit_cnt_reg <= bit_cnt_next;
         tx_reg      <= tx_next;
         busy_reg    <= busy_next;
`ifdef UART_TX_PARITY_EN
         parity_reg  <= parity_next;
`endif
      end
   end

   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt_reg;
`ifdef UART_TX_PARITY_EN
      parity_next  = accept ? ^tx_data : parity_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next   = START;
               shift_next   = tx_data;
               bit_cnt_next = '0;
            end
         end
         START: if (tick) state_next = DATA;
         DATA: begin
            if (tick) begin
               shift_next   = {1'b0, shift_reg[DATA_BITS-1:1]};
               bit_cnt_next = bit_cnt_reg + BW'(1);
               if (bit_cnt_reg == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end
         end
         PARITY:  if (tick) state_next = STOP;
         STOP:    if (tick) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so the start bit lands right after accept.
   always_comb begin
      busy_next = (state_next != IDLE);
      case (state_next)
         START:  tx_next = 1'b0;
         DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
         PARITY: tx_next = parity_next;
`endif
         default: tx_next = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level line model plus a decoding monitor.
module tb_uart_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
   localparam int FRAME_CYCLES = 44;
`else
   localparam int NBITS = 10;
   localparam int FRAME_CYCLES = 40;
`endif

   logic       clock = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_send = 1'b0;
   logic       tx_busy;
   logic       tx;

   uart_tx #(.CLK_FREQ(1_000_000), .BAUD(250_000)) dut (
      .clock   (clock),
      .rst     (rst),
      .tx_data (tx_data),
      .tx_send (tx_send),
      .tx_busy (tx_busy),
      .tx      (tx)
   );

   always #5 clock = ~clock;

   int         n_checks = 0;
   int         n_fail = 0;
   bit         exp_q[$];
   logic [7:0] sent_q[$];
   logic [7:0] dec_q[$];
   int         n_acc = 0;
   int         frames = 0;
   int         mon_cnt = -1;
   int         mon_k;
   logic [7:0] mon_byte = 8'h00;
   bit         check_en = 1'b0;
   bit         samp[0:63];
   int         cap_len;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic void push_bit(input bit b);
      repeat (CPB) exp_q.push_back(b);
   endfunction

   // Line model: a frame is a list of bit values, each held CPB cycles after the accept edge.
   always @(posedge clock or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         sent_q.delete();
      end else if (exp_q.size() > 0) begin
         void'(exp_q.pop_front());
      end else if (tx_send) begin
         push_bit(1'b0);
         for (int i = 0; i < 8; i++) push_bit(tx_data[i]);
`ifdef UART_TX_PARITY_EN
         push_bit(^tx_data);
`endif
         push_bit(1'b1);
         sent_q.push_back(tx_data);
         n_acc++;
      end
   end

   // Per-cycle comparison against the model, plus a mid-bit sampling decoder.
   always @(negedge clock) begin
      if (rst) begin
         mon_cnt = -1;
      end else begin
         if (check_en) begin
            check("tx_line", int'(tx), (exp_q.size() > 0) ? int'(exp_q[0]) : 1);
            check("tx_busy", int'(tx_busy), int'(exp_q.size() > 0));
         end
         if (mon_cnt < 0) begin
            if (tx == 1'b0) mon_cnt = 0;
         end else begin
            mon_cnt++;
         end
         if (mon_cnt > 0 && (mon_cnt % CPB) == CPB / 2) begin
            mon_k = mon_cnt / CPB;
            if (mon_k >= 1 && mon_k <= 8) begin
               mon_byte[mon_k-1] = tx;
            end
`ifdef UART_TX_PARITY_EN
            else if (mon_k == 9) begin
               check("parity_bit", int'(tx), int'(^mon_byte));
            end
`endif
            else if (mon_k == NBITS - 1) begin
               check("stop_bit", int'(tx), 1);
               frames++;
               dec_q.push_back(mon_byte);
               $display("frame %0d decoded 0x%02h at %0t", frames, mon_byte, $time);
               check("frame_pending", sent_q.size(), 1);
               if (sent_q.size() > 0) check("frame_data", int'(mon_byte), int'(sent_q.pop_front()));
               mon_cnt = -1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int i;
      i = 0;
      while (tx_busy && i < 200) begin
         step();
         i++;
      end
      if (tx_busy) check({name, "_timeout"}, int'(tx_busy), 0);
   endtask

   task automatic send_capture(input logic [7:0] d);
      tx_data = d;
      tx_send = 1'b1;
      step();
      tx_send = 1'b0;
      cap_len = 0;
      for (int i = 0; i < 200 && tx_busy === 1'b1; i++) begin
         if (i < 64) samp[i] = tx;
         cap_len++;
         step();
      end
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int bad_tx, bad_busy, n, f0, a0;
`ifdef UART_TX_PARITY_EN
      int pat_a5[NBITS] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
      int pat_a5[NBITS] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
      // Reset state and idle line
      rst = 1'b1;
      repeat (3) step();
      check("reset_tx", int'(tx), 1);
      check("reset_busy", int'(tx_busy), 0);
      rst = 1'b0;
      check_en = 1'b1;
      bad_tx = 0;
      bad_busy = 0;
      for (int i = 0; i < 50; i++) begin
         if (tx !== 1'b1) bad_tx++;
         if (tx_busy !== 1'b0) bad_busy++;
         step();
      end
      check("idle_tx_low_cycles", bad_tx, 0);
      check("idle_busy_cycles", bad_busy, 0);

      // Single byte with literal line pattern
      send_capture(8'hA5);
      check("a5_latency", int'(samp[0]), 0);
      for (int k = 0; k < NBITS; k++)
         check($sformatf("a5_bit%0d", k), int'(samp[k*CPB + CPB/2]), pat_a5[k]);
      check("a5_busy_len", cap_len, FRAME_CYCLES);
      repeat (5) step();

      // Back-to-back with tx_send held high
      dec_q.delete();
      tx_data = 8'h00;
      tx_send = 1'b1;
      step();
      tx_data = 8'hFF;
      n = 0;
      while (tx_busy && n < 200) begin
         step();
         n++;
      end
      check("b2b_first_len", n, FRAME_CYCLES);
      step();
      check("b2b_restart_busy", int'(tx_busy), 1);
      check("b2b_restart_tx", int'(tx), 0);
      tx_send = 1'b0;
      wait_idle("b2b");
      repeat (5) step();
      check("b2b_frames", dec_q.size(), 2);
      if (dec_q.size() == 2) begin
         check("b2b_byte0", int'(dec_q[0]), 8'h00);
         check("b2b_byte1", int'(dec_q[1]), 8'hFF);
      end

      // Request during a frame is ignored
      dec_q.delete();
      f0 = frames;
      tx_data = 8'h81;
      tx_send = 1'b1;
      step();
      tx_send = 1'b0;
      repeat (10) step();
      tx_data = 8'h3C;
      tx_send = 1'b1;
      step();
      tx_send = 1'b0;
      wait_idle("ignore");
      repeat (20) step();
      check("ignore_frames", frames - f0, 1);
      check("ignore_busy", int'(tx_busy), 0);
      if (dec_q.size() > 0) check("ignore_byte", int'(dec_q[0]), 8'h81);

      // Asynchronous reset mid-frame
      tx_data = 8'h55;
      tx_send = 1'b1;
      step();
      tx_send = 1'b0;
      repeat (17) step();
      check("pre_rst_busy", int'(tx_busy), 1);
      rst = 1'b1;
      #1;
      check("rst_async_tx", int'(tx), 1);
      check("rst_async_busy", int'(tx_busy), 0);
      step();
      step();
      rst = 1'b0;
      step();
      dec_q.delete();
      send_capture(8'h0F);
      check("post_rst_len", cap_len, FRAME_CYCLES);
      repeat (5) step();
      check("post_rst_frames", dec_q.size(), 1);
      if (dec_q.size() > 0) check("post_rst_byte", int'(dec_q[0]), 8'h0F);

`ifdef UART_TX_PARITY_EN
      send_capture(8'h07);
      check("par07_bit", int'(samp[9*CPB + CPB/2]), 1);
      check("par07_len", cap_len, 44);
      send_capture(8'h03);
      check("par03_bit", int'(samp[9*CPB + CPB/2]), 0);
      repeat (5) step();
`endif

      // Randomized requests and data, checked cycle by cycle against the model
      f0 = frames;
      a0 = n_acc;
      for (int c = 0; c < 2000; c++) begin
         tx_send = ($urandom_range(0, 3) == 0);
         tx_data = 8'($urandom);
         step();
      end
      tx_send = 1'b0;
      wait_idle("random");
      repeat (5) step();
      check("random_frames", frames - f0, n_acc - a0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter: the TX half of the uart block, pairing with the existing RX path.
- Accepts one byte per handshake from the user side and serialises it on the tx pin, LSB first.
- Frame is 1 start bit (0), 8 data bits, 1 stop bit (1), timed by an internal baud divider.
- Instantiated inside uart alongside the RX control and datapath; drives the physical tx pin directly.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- Derived constant CLKS_PER_BIT = CLK_FREQ / BAUD (integer truncation). Elaboration error if < 2.

Ports:
- clock  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  8  byte to send; sampled only on the accept cycle.
- tx_send  input  1  send request; level-sensitive, qualified by !tx_busy.
- tx_busy  output  1  high while a frame is in flight; new requests ignored.
- tx  output  1  UART serial output; idles high.

Behaviour:
- Reset (asynchronous, takes effect immediately): tx=1, tx_busy=0, FSM=IDLE, baud counter=0, bit counter=0, shift register=0. Reset mid-frame aborts the frame; the line returns high at once.
- FSM states and transitions:
  - IDLE: tx=1. On a rising edge with tx_send && !tx_busy, latch tx_data into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. Bit counter runs 0..7; after bit 7 go to STOP (or PARITY, see Optional Feature).
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- tx_busy is high in every state except IDLE. It rises the cycle after accept and falls the cycle after the last stop-bit cycle.
- Frame duration: tx_busy high for exactly 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
- Latency: the start bit appears on tx in the cycle immediately after the accept edge.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. It is cleared on accept, so the first bit is full length.
- Back-to-back: if tx_send is high in the first IDLE cycle after a frame, the next start bit follows with zero idle cycles. Frames are gap-free except for that one accept cycle, where tx=1 is part of IDLE.
- tx_send while busy: ignored, not queued. tx_data changes during a frame have no effect.
- tx is registered; there is no combinational path from inputs to tx or tx_busy.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 latched data bits) for CLKS_PER_BIT cycles. Frame is 11 bit-times; tx_busy is high for 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, plain 8N1 framing.

Decomposition:
- Shared package uart_pkg, also used by the RX side:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP}.
  - DATA_BITS = 8.
  - function clks_per_bit(CLK_FREQ, BAUD).
- One natural sub-module, uart_baud_tick: a parameterised counter with clear input and tick output (tick on count == CLKS_PER_BIT-1), reusable for RX oversampling.
- Shift register, bit counter and FSM stay in uart_tx.

Test Plan:
All scenarios use CLK_FREQ=1_000_000, BAUD=250_000, so CLKS_PER_BIT=4.
- Reset idle: hold rst 3 cycles, release, no send -> tx=1 and tx_busy=0 for 50 cycles.
- Single byte: tx_data=8'hA5, pulse tx_send 1 cycle -> line reads 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each value held 4 cycles; tx_busy high for exactly 40 cycles; monitor decodes 8'hA5.
- Back-to-back: hold tx_send=1 with 8'h00 then 8'hFF -> second start bit begins exactly 1 cycle after tx_busy falls; both bytes decoded correctly.
- Ignored request: pulse tx_send with 8'h3C at cycle 10 of a frame sending 8'h81 -> only 8'h81 transmitted; no second frame.
- Reset mid-frame: assert rst at cycle 17 of an 8'h55 frame -> tx=1 and tx_busy=0 in the same cycle (asynchronous); a new send of 8'h0F after release transmits cleanly.
- Parity (UART_TX_PARITY_EN defined): send 8'h07 -> parity bit 1 between data and stop; tx_busy high for 44 cycles. Send 8'h03 -> parity bit 0.
